// File: rtl/tx_packet_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tx_packet_ctrl_if : controller <-> byte stage / TX FIFO / host signals     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface tx_packet_ctrl_if;
  logic        tx_start;
  logic [3:0]  tx_pid;
  logic        tx_has_data;
  logic [6:0]  tx_len;
  logic        fifo_empty;
  logic [7:0]  FIFO_byte;
  logic        Load_Byte;
  logic        fifo_read;
  logic [7:0]  FSM_byte;
  logic [1:0]  select;
  logic [15:0] CRC_Bytes;
  logic        load_en;
  logic        Tim_rst;
  logic        Tim_en;
  logic        idle;
  logic        eop;
  logic        eop_new_bit;
  logic        busy;
  logic        tx_done;
  logic        tx_err;

  modport master (
    input  tx_start, tx_pid, tx_has_data, tx_len, fifo_empty, FIFO_byte, Load_Byte,
    output fifo_read, FSM_byte, select, CRC_Bytes, load_en, Tim_rst, Tim_en,
           idle, eop, eop_new_bit, busy, tx_done, tx_err
  );

  modport slave (
    output tx_start, tx_pid, tx_has_data, tx_len, fifo_empty, FIFO_byte, Load_Byte,
    input  fifo_read, FSM_byte, select, CRC_Bytes, load_en, Tim_rst, Tim_en,
           idle, eop, eop_new_bit, busy, tx_done, tx_err
  );
endinterface
`default_nettype wire

// File: rtl/tx_packet_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tx_packet_ctrl : USB FS packet sequencer (SYNC, PID, payload, CRC16, EOP)  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tx_packet_ctrl #(
  parameter int CLKS_PER_BIT = 8,
  parameter int MAX_LEN      = 64
) (
  input  logic             clk,
  input  logic             n_rst,
  tx_packet_ctrl_if.master pkt_io
);

  localparam int               TMR_W      = $clog2(2 * CLKS_PER_BIT) + 1;
  localparam logic [TMR_W-1:0] C_EOP_LAST = TMR_W'(2 * CLKS_PER_BIT - 1);
  localparam logic [TMR_W-1:0] C_BIT_LAST = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [TMR_W-1:0] C_BIT_TWO  = TMR_W'(CLKS_PER_BIT);
  localparam logic [6:0]       C_MAX_LEN  = 7'(MAX_LEN);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SYNC   = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_CRC    = 3'd3;
  localparam logic [2:0] S_CRC_HI = 3'd4;
  localparam logic [2:0] S_LAST   = 3'd5;
  localparam logic [2:0] S_EOP    = 3'd6;
  localparam logic [2:0] S_J      = 3'd7;

  logic [2:0]       state_q, state_d;
  logic [3:0]       pid_q, pid_d;
  logic             has_data_q, has_data_d;
  logic [6:0]       len_q, len_d;
  logic [6:0]       cnt_q, cnt_d;
  logic [15:0]      crc_q, crc_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [6:0]       cnt_inc;
  logic [7:0]       pid_byte;

  // Reflected form of poly 0x8005, data consumed LSB first.
  function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 16'hA001;
      else             r = r >> 1;
    end
    return r;
  endfunction

  assign cnt_inc  = cnt_q + 7'd1;
  assign pid_byte = {~pid_q, pid_q};

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= S_IDLE;
      pid_q      <= 4'h0;
      has_data_q <= 1'b0;
      len_q      <= 7'd0;
      cnt_q      <= 7'd0;
      crc_q      <= 16'hFFFF;
      tmr_q      <= '0;
    end else begin
      state_q    <= state_d;
      pid_q      <= pid_d;
      has_data_q <= has_data_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      crc_q      <= crc_d;
      tmr_q      <= tmr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pid_d      = pid_q;
    has_data_d = has_data_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    crc_d      = crc_q;
    tmr_d      = '0;
    case (state_q)
      S_IDLE: if (pkt_io.tx_start) begin
        pid_d      = pkt_io.tx_pid;
        has_data_d = pkt_io.tx_has_data;
        len_d      = (pkt_io.tx_len > C_MAX_LEN) ? C_MAX_LEN : pkt_io.tx_len;
        cnt_d      = 7'd0;
        crc_d      = 16'hFFFF;
        state_d    = S_SYNC;
      end
      S_SYNC: if (pkt_io.Load_Byte) begin
        if (!has_data_q)        state_d = S_LAST;
        else if (len_q == 7'd0) state_d = S_CRC;
        else                    state_d = S_DATA;
      end
      // An empty FIFO on a byte boundary aborts straight into EOP.
      S_DATA: if (pkt_io.Load_Byte) begin
        if (pkt_io.fifo_empty) begin
          state_d = S_EOP;
        end else begin
          crc_d = crc16_upd(crc_q, pkt_io.FIFO_byte);
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) state_d = S_CRC;
        end
      end
      S_CRC:    if (pkt_io.Load_Byte) state_d = S_CRC_HI;
      S_CRC_HI: if (pkt_io.Load_Byte) state_d = S_LAST;
      S_LAST:   if (pkt_io.Load_Byte) state_d = S_EOP;
      S_EOP: begin
        if (tmr_q == C_EOP_LAST) state_d = S_J;
        else                     tmr_d   = tmr_q + 1'b1;
      end
      S_J: begin
        if (tmr_q == C_BIT_LAST) state_d = S_IDLE;
        else                     tmr_d   = tmr_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pkt_io.fifo_read   = 1'b0;
    pkt_io.FSM_byte    = 8'h00;
    pkt_io.select      = 2'd1;
    pkt_io.load_en     = 1'b0;
    pkt_io.Tim_rst     = 1'b0;
    pkt_io.Tim_en      = 1'b0;
    pkt_io.idle        = 1'b0;
    pkt_io.eop         = 1'b0;
    pkt_io.eop_new_bit = 1'b0;
    pkt_io.busy        = 1'b1;
    pkt_io.tx_done     = 1'b0;
    pkt_io.tx_err      = 1'b0;
    pkt_io.CRC_Bytes   = ~crc_q;
    case (state_q)
      S_IDLE: begin
        pkt_io.busy = pkt_io.tx_start;
        pkt_io.idle = ~pkt_io.tx_start;
        if (pkt_io.tx_start) begin
          pkt_io.FSM_byte = 8'h80;
          pkt_io.load_en  = 1'b1;
          pkt_io.Tim_rst  = 1'b1;
        end
      end
      S_SYNC, S_LAST: begin
        pkt_io.Tim_en   = 1'b1;
        pkt_io.FSM_byte = pid_byte;
      end
      S_DATA: begin
        pkt_io.Tim_en    = 1'b1;
        pkt_io.select    = 2'd0;
        pkt_io.FSM_byte  = pid_byte;
        pkt_io.fifo_read = pkt_io.Load_Byte & ~pkt_io.fifo_empty;
        pkt_io.tx_err    = pkt_io.Load_Byte &  pkt_io.fifo_empty;
      end
      S_CRC: begin
        pkt_io.Tim_en = 1'b1;
        pkt_io.select = 2'd2;
      end
      S_CRC_HI: begin
        pkt_io.Tim_en = 1'b1;
        pkt_io.select = 2'd3;
      end
      S_EOP: begin
        pkt_io.eop         = 1'b1;
        pkt_io.eop_new_bit = (tmr_q == '0) || (tmr_q == C_BIT_TWO);
      end
      S_J: begin
        pkt_io.idle        = 1'b1;
        pkt_io.eop_new_bit = (tmr_q == '0);
        pkt_io.tx_done     = (tmr_q == C_BIT_LAST);
      end
      default: begin
        pkt_io.busy = 1'b0;
        pkt_io.idle = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire
